// File: rtl/psram_arbiter_if.sv
// Requester/controller bundle for psram_arbiter. The master modport is the arbiter's
// view; the slave modport is the view of the requesters and the PSRAM controller.
interface psram_arbiter_if;
  // framebuffer read requester
  logic        i_rd_req;
  logic        o_rd_gnt;
  logic [20:0] i_rd_addr;
  logic [63:0] o_rd_data;
  logic        o_rd_data_valid;
  // framebuffer write requester
  logic        i_wr_req;
  logic        o_wr_gnt;
  logic [20:0] i_wr_addr;
  logic [63:0] i_wr_data;
  logic        o_wr_data_ack;
  // PSRAM controller port
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic        o_cmd_write;
  logic [20:0] o_cmd_addr;
  logic [63:0] o_wdata;
  logic        i_wdata_req;
  logic [63:0] i_rdata;
  logic        i_rdata_valid;
  logic        o_busy;

  modport master (
    input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
    input  i_cmd_ready, i_wdata_req, i_rdata, i_rdata_valid,
    output o_rd_gnt, o_rd_data, o_rd_data_valid,
    output o_wr_gnt, o_wr_data_ack,
    output o_cmd_valid, o_cmd_write, o_cmd_addr, o_wdata, o_busy
  );

  modport slave (
    output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
    output i_cmd_ready, i_wdata_req, i_rdata, i_rdata_valid,
    input  o_rd_gnt, o_rd_data, o_rd_data_valid,
    input  o_wr_gnt, o_wr_data_ack,
    input  o_cmd_valid, o_cmd_write, o_cmd_addr, o_wdata, o_busy
  );
endinterface

// File: rtl/psram_arbiter.sv
// Burst-granular arbiter sharing one PSRAM controller port between the display read
// path (priority) and the SPI write path, with a streak limit against writer starvation.
module psram_arbiter #(
  parameter int BURST_BEATS     = 8,
  parameter int WR_STARVE_LIMIT = 4
) (
  input  logic           i_psram_clk,
  input  logic           i_psram_rst_n,
  psram_arbiter_if.master bus
);

  localparam int BW = (BURST_BEATS < 2) ? 1 : $clog2(BURST_BEATS);
  localparam int SW = (WR_STARVE_LIMIT < 8) ? 3 : $clog2(WR_STARVE_LIMIT + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_BEATS - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(WR_STARVE_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_CMD,
    ST_RD_DATA,
    ST_WR_DATA
  } state_t;

  state_t        r_state,      w_state_next;
  logic          r_owner_wr,   w_owner_wr_next;
  logic          r_rd_gnt,     w_rd_gnt_next;
  logic          r_wr_gnt,     w_wr_gnt_next;
  logic          r_cmd_valid,  w_cmd_valid_next;
  logic          r_cmd_write,  w_cmd_write_next;
  logic [20:0]   r_cmd_addr,   w_cmd_addr_next;
  logic [BW-1:0] r_beat,       w_beat_next;
  logic [SW-1:0] r_streak,     w_streak_next;
  logic          r_busy,       w_busy_next;
  logic          w_wr_wins;

  // The writer overtakes a pending read only once the read streak has saturated.
  assign w_wr_wins = bus.i_wr_req &&
                     (!bus.i_rd_req ||
                      ((WR_STARVE_LIMIT != 0) && (r_streak >= STREAK_MAX)));

  always_ff @(posedge i_psram_clk or negedge i_psram_rst_n) begin
    if (!i_psram_rst_n) begin
      r_state     <= ST_IDLE;
      r_owner_wr  <= 1'b0;
      r_rd_gnt    <= 1'b0;
      r_wr_gnt    <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_beat      <= '0;
      r_streak    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_owner_wr  <= w_owner_wr_next;
      r_rd_gnt    <= w_rd_gnt_next;
      r_wr_gnt    <= w_wr_gnt_next;
      r_cmd_valid <= w_cmd_valid_next;
      r_cmd_write <= w_cmd_write_next;
      r_cmd_addr  <= w_cmd_addr_next;
      r_beat      <= w_beat_next;
      r_streak    <= w_streak_next;
      r_busy      <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_owner_wr_next  = r_owner_wr;
    w_rd_gnt_next    = 1'b0;
    w_wr_gnt_next    = 1'b0;
    w_cmd_valid_next = r_cmd_valid;
    w_cmd_write_next = r_cmd_write;
    w_cmd_addr_next  = r_cmd_addr;
    w_beat_next      = r_beat;
    w_streak_next    = r_streak;

    case (r_state)
      ST_IDLE: begin
        if (!bus.i_wr_req) begin
          w_streak_next = '0;
        end
        if (w_wr_wins) begin
          w_owner_wr_next = 1'b1;
          w_wr_gnt_next   = 1'b1;
          w_streak_next   = '0;
          w_state_next    = ST_GRANT;
        end else if (bus.i_rd_req) begin
          w_owner_wr_next = 1'b0;
          w_rd_gnt_next   = 1'b1;
          w_state_next    = ST_GRANT;
          if (bus.i_wr_req && (r_streak < STREAK_MAX)) begin
            w_streak_next = r_streak + SW'(1);
          end
        end
      end

      // Requester sees gnt on this edge and advances its address afterwards.
      ST_GRANT: begin
        w_cmd_addr_next  = r_owner_wr ? bus.i_wr_addr : bus.i_rd_addr;
        w_cmd_write_next = r_owner_wr;
        w_cmd_valid_next = 1'b1;
        w_state_next     = ST_CMD;
      end

      ST_CMD: begin
        if (bus.i_cmd_ready) begin
          w_cmd_valid_next = 1'b0;
          w_beat_next      = '0;
          w_state_next     = r_owner_wr ? ST_WR_DATA : ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (bus.i_rdata_valid) begin
          if (r_beat == LAST_BEAT) begin
            w_beat_next  = '0;
            w_state_next = ST_IDLE;
          end else begin
            w_beat_next = r_beat + BW'(1);
          end
        end
      end

      ST_WR_DATA: begin
        if (bus.i_wdata_req) begin
          if (r_beat == LAST_BEAT) begin
            w_beat_next  = '0;
            w_state_next = ST_IDLE;
          end else begin
            w_beat_next = r_beat + BW'(1);
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  assign bus.o_rd_gnt        = r_rd_gnt;
  assign bus.o_wr_gnt        = r_wr_gnt;
  assign bus.o_cmd_valid     = r_cmd_valid;
  assign bus.o_cmd_write     = r_cmd_write;
  assign bus.o_cmd_addr      = r_cmd_addr;
  assign bus.o_busy          = r_busy;

  // Data paths are pure pass-through; only the strobes are gated by burst ownership.
  assign bus.o_rd_data       = bus.i_rdata;
  assign bus.o_rd_data_valid = bus.i_rdata_valid & (r_state == ST_RD_DATA);
  assign bus.o_wdata         = bus.i_wr_data;
  assign bus.o_wr_data_ack   = bus.i_wdata_req & (r_state == ST_WR_DATA);

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: stimulus pushes expected grants, commands and
// beats into queues; a forked monitor pops and compares whenever the DUT presents them.
module tb_psram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  psram_arbiter_if u_if ();
  psram_arbiter_if u_if0 ();

  psram_arbiter #(.BURST_BEATS(8), .WR_STARVE_LIMIT(4)) u_dut (
    .i_psram_clk   (clk),
    .i_psram_rst_n (rst_n),
    .bus           (u_if.master)
  );

  psram_arbiter #(.BURST_BEATS(8), .WR_STARVE_LIMIT(0)) u_dut0 (
    .i_psram_clk   (clk),
    .i_psram_rst_n (rst_n),
    .bus           (u_if0.master)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  gnt_q[$];   // {wr_gnt, rd_gnt}
  logic [21:0] cmd_q[$];   // {write, addr}
  logic [63:0] rd_q[$];
  logic [63:0] wr_q[$];

  function automatic logic [63:0] rd_pat(input logic [20:0] a, input int b);
    return {32'hC0DE_0000 | 32'(b), 11'b0, a};
  endfunction

  function automatic logic [63:0] wr_pat(input logic [20:0] a, input int b);
    return {32'hBEEF_0000 | 32'(b), 11'b0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got strobe with empty scoreboard, required none", name);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (u_if.o_rd_gnt || u_if.o_wr_gnt) begin
        if (gnt_q.size() == 0) unexpected("gnt");
        else chk("gnt_owner", 64'({u_if.o_wr_gnt, u_if.o_rd_gnt}), 64'(gnt_q.pop_front()));
      end
      if (u_if.o_cmd_valid && u_if.i_cmd_ready) begin
        if (cmd_q.size() == 0) unexpected("cmd");
        else chk("cmd_write_addr", 64'({u_if.o_cmd_write, u_if.o_cmd_addr}), 64'(cmd_q.pop_front()));
      end
      if (u_if.o_rd_data_valid) begin
        if (rd_q.size() == 0) unexpected("rd_data_valid");
        else chk("rd_data", u_if.o_rd_data, rd_q.pop_front());
      end
      if (u_if.o_wr_data_ack) begin
        if (wr_q.size() == 0) unexpected("wr_data_ack");
        else chk("wr_data", u_if.o_wdata, wr_q.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit wr);
    int n;
    n = 0;
    while (!(wr ? u_if.o_wr_gnt : u_if.o_rd_gnt) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant, required %s grant", wr ? "write" : "read");
    end
  endtask

  // Read burst of nb beats; stray strobes are driven while the command waits.
  task automatic rd_burst(input logic [20:0] addr, input int dly, input int gap,
                          input bit stray, input int nb);
    u_if.i_rd_addr = addr;
    u_if.i_rd_req  = 1'b1;
    gnt_q.push_back(2'b01);
    cmd_q.push_back({1'b0, addr});
    tick();
    wait_gnt(1'b0);
    u_if.i_rd_req = 1'b0;
    tick();
    chk("rd_gnt_pulse", 64'(u_if.o_rd_gnt), 64'(0));
    chk("cmd_valid_up", 64'(u_if.o_cmd_valid), 64'(1));
    chk("busy_in_burst", 64'(u_if.o_busy), 64'(1));
    for (int i = 0; i < dly; i++) begin
      u_if.i_rdata_valid = stray;
      u_if.i_rdata       = 64'hDEAD_DEAD_DEAD_DEAD;
      tick();
    end
    u_if.i_rdata_valid = 1'b0;
    u_if.i_cmd_ready   = 1'b1;
    tick();
    u_if.i_cmd_ready = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gap; g++) tick();
      if (b == 7) chk("busy_pre_last_rd", 64'(u_if.o_busy), 64'(1));
      u_if.i_rdata       = rd_pat(addr, b);
      u_if.i_rdata_valid = 1'b1;
      rd_q.push_back(rd_pat(addr, b));
      tick();
      u_if.i_rdata_valid = 1'b0;
    end
    if (nb == 8) chk("busy_after_rd", 64'(u_if.o_busy), 64'(0));
  endtask

  task automatic wr_burst(input logic [20:0] addr);
    u_if.i_wr_addr = addr;
    u_if.i_wr_req  = 1'b1;
    gnt_q.push_back(2'b10);
    cmd_q.push_back({1'b1, addr});
    tick();
    wait_gnt(1'b1);
    u_if.i_wr_req = 1'b0;
    tick();
    chk("cmd_write_flag", 64'(u_if.o_cmd_write), 64'(1));
    u_if.i_cmd_ready = 1'b1;
    tick();
    u_if.i_cmd_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == 7) chk("busy_pre_last_wr", 64'(u_if.o_busy), 64'(1));
      u_if.i_wr_data   = wr_pat(addr, b);
      u_if.i_wdata_req = 1'b1;
      wr_q.push_back(wr_pat(addr, b));
      tick();
      u_if.i_wdata_req = 1'b0;
      if (b % 3 == 1) tick();
    end
    chk("busy_after_wr", 64'(u_if.o_busy), 64'(0));
  endtask

  initial begin
    logic [1:0] pat [10];
    int rd_cnt;
    int wr_cnt;
    int n;

    {u_if.i_rd_req, u_if.i_wr_req, u_if.i_cmd_ready, u_if.i_wdata_req, u_if.i_rdata_valid} = '0;
    u_if.i_rd_addr = '0; u_if.i_wr_addr = '0; u_if.i_wr_data = '0; u_if.i_rdata = '0;
    {u_if0.i_rd_req, u_if0.i_wr_req, u_if0.i_cmd_ready, u_if0.i_wdata_req, u_if0.i_rdata_valid} = '0;
    u_if0.i_rd_addr = 21'h11; u_if0.i_wr_addr = 21'h22; u_if0.i_wr_data = '0; u_if0.i_rdata = '0;
    rst_n = 1'b0;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) tick();
    chk("rst_gnts", 64'({u_if.o_rd_gnt, u_if.o_wr_gnt}), 64'(0));
    chk("rst_cmd", 64'({u_if.o_cmd_valid, u_if.o_cmd_write, u_if.o_cmd_addr}), 64'(0));
    chk("rst_busy_strobes", 64'({u_if.o_busy, u_if.o_rd_data_valid, u_if.o_wr_data_ack}), 64'(0));
    chk("rst_data", u_if.o_rd_data | u_if.o_wdata, 64'(0));
    rst_n = 1'b1;
    tick();

    // first read burst with slow command accept, gapped beats, stray strobes in CMD
    rd_burst(21'h40, 3, 1, 1'b1, 8);
    u_if.i_rdata_valid = 1'b1;
    #1 chk("stray_rd_idle", 64'(u_if.o_rd_data_valid), 64'(0));
    tick();
    u_if.i_rdata_valid = 1'b0;
    tick();

    // write burst followed by a stray ninth beat request
    wr_burst(21'h1000);
    u_if.i_wdata_req = 1'b1;
    #1 chk("stray_wr_ack", 64'(u_if.o_wr_data_ack), 64'(0));
    tick();
    u_if.i_wdata_req = 1'b0;
    tick();

    // both requesters constantly active, limit 4
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    u_if.i_rd_addr = 21'h200;
    u_if.i_wr_addr = 21'h300;
    for (int i = 0; i < 10; i++) begin
      gnt_q.push_back(pat[i]);
      cmd_q.push_back(pat[i][1] ? {1'b1, 21'h300} : {1'b0, 21'h200});
    end
    u_if.i_rd_req = 1'b1;
    u_if.i_wr_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bit w;
      n = 0;
      do begin
        tick();
        n++;
      end while (!(u_if.o_rd_gnt || u_if.o_wr_gnt) && n < 40);
      if (n >= 40) begin
        checks++;
        errors++;
        $display("FAIL contend_timeout: got no grant, required grant %0d", k);
        break;
      end
      w = u_if.o_wr_gnt;
      if (k == 9) begin
        u_if.i_rd_req = 1'b0;
        u_if.i_wr_req = 1'b0;
      end
      u_if.i_cmd_ready = 1'b1;
      tick();
      tick();
      u_if.i_cmd_ready = 1'b0;
      for (int b = 0; b < 8; b++) begin
        if (w) begin
          u_if.i_wr_data   = wr_pat(21'h300, b + 16 * k);
          u_if.i_wdata_req = 1'b1;
          wr_q.push_back(wr_pat(21'h300, b + 16 * k));
        end else begin
          u_if.i_rdata       = rd_pat(21'h200, b + 16 * k);
          u_if.i_rdata_valid = 1'b1;
          rd_q.push_back(rd_pat(21'h200, b + 16 * k));
        end
        tick();
      end
      u_if.i_wdata_req   = 1'b0;
      u_if.i_rdata_valid = 1'b0;
    end
    u_if.i_rd_req = 1'b0;
    u_if.i_wr_req = 1'b0;
    tick();

    // limit 0 instance: writer must never win against a pending read
    rd_cnt = 0;
    wr_cnt = 0;
    {u_if0.i_rd_req, u_if0.i_wr_req, u_if0.i_cmd_ready, u_if0.i_wdata_req, u_if0.i_rdata_valid} = '1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (u_if0.o_rd_gnt) rd_cnt++;
      if (u_if0.o_wr_gnt) wr_cnt++;
    end
    {u_if0.i_rd_req, u_if0.i_wr_req} = '0;
    chk("lim0_wr_gnts", 64'(wr_cnt), 64'(0));
    chk("lim0_rd_gnts", 64'(rd_cnt), 64'(19));

    // reset mid-burst after three read beats
    rd_burst(21'h80, 0, 0, 1'b0, 3);
    u_if.i_rdata_valid = 1'b1;
    u_if.i_rdata       = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnts_cmd", 64'({u_if.o_rd_gnt, u_if.o_wr_gnt, u_if.o_cmd_valid, u_if.o_cmd_write}), 64'(0));
    chk("midrst_addr", 64'(u_if.o_cmd_addr), 64'(0));
    chk("midrst_busy_strobes", 64'({u_if.o_busy, u_if.o_rd_data_valid, u_if.o_wr_data_ack}), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_if.i_rdata = rd_pat(21'h80, 3 + i);
      tick();
      chk("late_beat_ignored", 64'(u_if.o_rd_data_valid), 64'(0));
    end
    u_if.i_rdata_valid = 1'b0;
    tick();
    wr_burst(21'h2000);
    repeat (3) tick();

    chk("scoreboard_empty", 64'(gnt_q.size() + cmd_q.size() + rd_q.size() + wr_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
